spi_burst_arbiter: RTL and testbench



---
 rtl/spi_pkg.sv | 16 +
 rtl/rr_arbiter.sv | 32 +++
 rtl/spi_burst_arbiter.sv | 139 +++++++++++++
 tb/tb_spi_burst_arbiter.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// spi_pkg: burst FSM state encoding and timing defaults shared with the SPI master engine wrapper.
package spi_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_WAIT_BUSY,
        S_WAIT_DONE,
        S_GAP,
        S_FINISH
    } state_e;

    localparam int TIMEOUT_DEFAULT = 64;
    localparam int GAP_DEFAULT     = 2;

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick starting one past the last winner.
//   req -> pending requests, ptr -> last winner,
//   gnt -> one-hot pick, idx -> pick index, any -> some request pending.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    output logic [NUM_REQ-1:0] gnt,
    output logic [ID_W-1:0]    idx,
    output logic               any
);

    logic [ID_W-1:0] j;

    always_comb begin
        gnt = '0;
        idx = '0;
        any = 1'b0;
        j   = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            j = ID_W'((int'(ptr) + k) % NUM_REQ);
            if (!any && req[j]) begin
                any    = 1'b1;
                idx    = j;
                gnt[j] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/spi_burst_arbiter.sv
// spi_burst_arbiter: round-robin sharing of one byte-level SPI engine with multi-byte bursts.
//   req/req_len/req_tx  -> per-requester request, burst length-1, current TX byte
//   tx_ack/gnt          <- per-requester byte-consumed pulse and burst grant
//   rx_valid/rx_data/rx_id <- received byte tagged with requester index
//   done/err            <- end-of-burst pulse, err marks a timeout abort
//   eng_start/eng_tx    -> engine handshake; eng_busy/eng_rx <- engine status and data
module spi_burst_arbiter
    import spi_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int LEN_W      = 4,
    parameter int GAP_CYCLES = GAP_DEFAULT,
    parameter int TIMEOUT    = TIMEOUT_DEFAULT
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [NUM_REQ*LEN_W-1:0]   req_len,
    input  logic [NUM_REQ*8-1:0]       req_tx,
    output logic [NUM_REQ-1:0]         tx_ack,
    output logic [NUM_REQ-1:0]         gnt,
    output logic                       rx_valid,
    output logic [7:0]                 rx_data,
    output logic [$clog2(NUM_REQ)-1:0] rx_id,
    output logic                       done,
    output logic                       err,
    output logic                       eng_start,
    output logic [7:0]                 eng_tx,
    input  logic                       eng_busy,
    input  logic [7:0]                 eng_rx
);

    localparam int ID_W  = $clog2(NUM_REQ);
    localparam int WD_W  = $clog2(TIMEOUT + 1);
    localparam int GAP_W = GAP_CYCLES > 1 ? $clog2(GAP_CYCLES) : 1;

    state_e             state_q, state_d;
    logic [NUM_REQ-1:0] gnt_q;
    logic [ID_W-1:0]    ptr_q, win_q, rx_id_q;
    logic [LEN_W-1:0]   len_q, cnt_q;
    logic [WD_W-1:0]    wd_q;
    logic [GAP_W-1:0]   gap_q;
    logic [7:0]         eng_tx_q, rx_data_q;
    logic               rx_valid_q, err_q;

    logic [NUM_REQ-1:0] arb_gnt;
    logic [ID_W-1:0]    arb_idx;
    logic               arb_any;
    logic [7:0]         lane_tx;
    logic [LEN_W-1:0]   lane_len;
    logic               timeout, last_byte;

    rr_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_arb (
        .req (req),
        .ptr (ptr_q),
        .gnt (arb_gnt),
        .idx (arb_idx),
        .any (arb_any)
    );

    assign lane_tx   = req_tx[int'(win_q) * 8 +: 8];
    assign lane_len  = req_len[int'(arb_idx) * LEN_W +: LEN_W];
    // Watchdog runs from the start pulse, so the abort lands TIMEOUT cycles after it.
    assign timeout   = wd_q == WD_W'(TIMEOUT - 1);
    assign last_byte = cnt_q == len_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            gnt_q      <= '0;
            ptr_q      <= ID_W'(NUM_REQ - 1);
            win_q      <= '0;
            len_q      <= '0;
            cnt_q      <= '0;
            wd_q       <= '0;
            gap_q      <= '0;
            eng_tx_q   <= '0;
            rx_data_q  <= '0;
            rx_id_q    <= '0;
            rx_valid_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            rx_valid_q <= 1'b0;
            wd_q       <= (state_q == S_LOAD || state_q == S_WAIT_BUSY) ? wd_q + 1'b1 : '0;
            gap_q      <= state_q == S_GAP ? gap_q + 1'b1 : '0;
            if (state_q == S_IDLE && arb_any) begin
                gnt_q <= arb_gnt;
                ptr_q <= arb_idx;
                win_q <= arb_idx;
                len_q <= lane_len;
                cnt_q <= '0;
            end
            if (state_q == S_LOAD)
                eng_tx_q <= lane_tx;
            if (state_q == S_WAIT_DONE && !eng_busy) begin
                rx_data_q  <= eng_rx;
                rx_id_q    <= win_q;
                rx_valid_q <= 1'b1;
                if (!last_byte)
                    cnt_q <= cnt_q + 1'b1;
            end
            if (state_d == S_FINISH)
                err_q <= state_q == S_WAIT_BUSY;
            if (state_q == S_FINISH)
                gnt_q <= '0;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:      state_d = arb_any ? S_LOAD : S_IDLE;
            S_LOAD:      state_d = S_WAIT_BUSY;
            S_WAIT_BUSY: state_d = eng_busy ? S_WAIT_DONE : (timeout ? S_FINISH : S_WAIT_BUSY);
            S_WAIT_DONE: state_d = eng_busy ? S_WAIT_DONE :
                                   last_byte ? S_FINISH :
                                   (GAP_CYCLES == 0 ? S_LOAD : S_GAP);
            S_GAP:       state_d = gap_q == GAP_W'(GAP_CYCLES - 1) ? S_LOAD : S_GAP;
            default:     state_d = S_IDLE;
        endcase
    end

    // The TX byte goes straight through during LOAD so it is valid with the start pulse,
    // then the captured copy holds it steady while the engine shifts.
    always_comb begin
        eng_start = state_q == S_LOAD;
        tx_ack    = eng_start ? gnt_q : '0;
        eng_tx    = eng_start ? lane_tx : eng_tx_q;
        done      = state_q == S_FINISH;
        err       = done & err_q;
    end

    assign gnt      = gnt_q;
    assign rx_valid = rx_valid_q;
    assign rx_data  = rx_data_q;
    assign rx_id    = rx_id_q;

endmodule

// File: tb/tb_spi_burst_arbiter.sv
// tb_spi_burst_arbiter: directed vectors plus corner-case sequences for spi_burst_arbiter.
module tb_spi_burst_arbiter;

    localparam int N   = 4;
    localparam int LW  = 4;
    localparam int GAP = 2;
    localparam int TO  = 64;

    logic          clk = 1'b0;
    logic          reset_n = 1'b1;
    logic [3:0]    req = '0;
    logic [15:0]   req_len = '0;
    logic [31:0]   req_tx;
    logic [3:0]    tx_ack, gnt;
    logic          rx_valid, done, err, eng_start;
    logic [7:0]    rx_data, eng_tx;
    logic [1:0]    rx_id;
    logic          eng_busy = 1'b0;
    logic [7:0]    eng_rx = '0;

    spi_burst_arbiter #(.NUM_REQ(N), .LEN_W(LW), .GAP_CYCLES(GAP), .TIMEOUT(TO)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .req       (req),
        .req_len   (req_len),
        .req_tx    (req_tx),
        .tx_ack    (tx_ack),
        .gnt       (gnt),
        .rx_valid  (rx_valid),
        .rx_data   (rx_data),
        .rx_id     (rx_id),
        .done      (done),
        .err       (err),
        .eng_start (eng_start),
        .eng_tx    (eng_tx),
        .eng_busy  (eng_busy),
        .eng_rx    (eng_rx)
    );

    always #5 clk = ~clk;

    typedef struct { int cyc; logic [7:0] tx; } start_t;
    typedef struct { logic [7:0] data; logic [1:0] id; } rx_t;
    typedef struct { int cyc; logic err; logic [3:0] gnt; } done_t;
    typedef struct { int lane; int len; logic [31:0] txs; logic [7:0] rx_last; } row_t;

    start_t start_q[$];
    rx_t    rx_q[$];
    done_t  done_q[$];
    int     fall_q[$];

    int errors = 0;
    int checks = 0;
    int eng_mode = 1;

    logic [7:0] tx_tab [4][4] = '{'{8'hA5, 8'hB6, 8'hC7, 8'hD8},
                                  '{8'h01, 8'h02, 8'h03, 8'h04},
                                  '{8'h11, 8'h22, 8'h33, 8'h44},
                                  '{8'h5A, 8'h6B, 8'h7C, 8'h8D}};
    int         tx_idx [4] = '{0, 0, 0, 0};
    logic [3:0] ack;
    logic [7:0] eng_cap;
    logic       eng_rst;

    function automatic int now_cyc();
        return int'($time / 10);
    endfunction

    function automatic int idx_of(logic [3:0] g);
        for (int i = 0; i < 4; i++)
            if (g == (4'b1 << i)) return i;
        return -1;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic clear_logs();
        start_q.delete();
        rx_q.delete();
        done_q.delete();
        fall_q.delete();
    endtask

    task automatic wait_dones(input int n, input int budget);
        int k = 0;
        while (done_q.size() < n && k < budget) begin
            @(negedge clk);
            #1;
            k++;
        end
        check($sformatf("wait_done_%0d", n), done_q.size() >= n, 1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 reset_n = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
    endtask

    always_comb
        for (int i = 0; i < 4; i++)
            req_tx[i*8 +: 8] = tx_tab[i][tx_idx[i]];

    // Requesters: restart their byte list between bursts, advance one byte per tx_ack.
    initial forever begin
        @(negedge clk);
        if (gnt == 4'b0) begin
            for (int i = 0; i < 4; i++) tx_idx[i] = 0;
        end else if (|tx_ack) begin
            ack = tx_ack;
            @(posedge clk);
            #1;
            for (int i = 0; i < 4; i++)
                if (ack[i]) tx_idx[i] = (tx_idx[i] + 1) % 4;
        end
    end

    // Engine model: busy one cycle after start for 16 cycles, returns tx ^ 0x99.
    initial forever begin
        @(negedge clk);
        if (eng_start && !eng_busy && eng_mode == 1) begin
            eng_cap = eng_tx;
            eng_rst = 1'b0;
            @(negedge clk);
            eng_busy = 1'b1;
            repeat (16) begin
                @(negedge clk);
                if (!reset_n) eng_rst = 1'b1;
            end
            eng_rx   = eng_cap ^ 8'h99;
            eng_busy = 1'b0;
            fall_q.push_back(now_cyc());
            if (!eng_rst && reset_n) check("eng_tx_stable", eng_tx, eng_cap);
        end
    end

    always @(negedge clk) begin
        if (eng_start) start_q.push_back('{now_cyc(), eng_tx});
        if (rx_valid)  rx_q.push_back('{rx_data, rx_id});
        if (done)      done_q.push_back('{now_cyc(), err, gnt});
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        row_t rows [4];
        int   exp_order [5];
        int   k;
        logic [7:0] exp_tx;
        rows[0] = '{0, 0, 32'h000000A5, 8'h3C};
        rows[1] = '{2, 3, 32'h44332211, 8'hDD};
        rows[2] = '{3, 1, 32'h00006B5A, 8'hF2};
        rows[3] = '{1, 2, 32'h00030201, 8'h9A};
        exp_order = '{0, 1, 2, 3, 0};

        #1 reset_n = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_gnt", gnt, 0);
        check("rst_eng_start", eng_start, 0);
        check("rst_done", {done, err, rx_valid}, 0);
        check("rst_tx_ack", tx_ack, 0);
        check("rst_eng_tx", eng_tx, 0);
        check("rst_rx", {rx_data, rx_id}, 0);
        reset_n = 1'b1;

        foreach (rows[r]) begin
            clear_logs();
            @(negedge clk);
            req_len[rows[r].lane*4 +: 4] = 4'(rows[r].len);
            req[rows[r].lane] = 1'b1;
            wait_dones(1, 500);
            req = '0;
            check($sformatf("r%0d_nstart", r), start_q.size(), rows[r].len + 1);
            check($sformatf("r%0d_nrx", r), rx_q.size(), rows[r].len + 1);
            check($sformatf("r%0d_ndone", r), done_q.size(), 1);
            if (done_q.size() > 0) begin
                check($sformatf("r%0d_err", r), done_q[0].err, 0);
                check($sformatf("r%0d_gnt", r), idx_of(done_q[0].gnt), rows[r].lane);
            end
            for (int b = 0; b <= rows[r].len; b++) begin
                exp_tx = rows[r].txs[b*8 +: 8];
                check($sformatf("r%0d_tx%0d", r, b), b < start_q.size() ? start_q[b].tx : 8'hxx, exp_tx);
                check($sformatf("r%0d_rx%0d", r, b), b < rx_q.size() ? {rx_q[b].id, rx_q[b].data} : 10'hxxx,
                      {2'(rows[r].lane), exp_tx ^ 8'h99});
                if (b > 0)
                    check($sformatf("r%0d_gap%0d", r, b),
                          b < start_q.size() && b <= fall_q.size() ? start_q[b].cyc - fall_q[b-1] : -1, GAP + 1);
            end
            check($sformatf("r%0d_rx_last", r), rx_q.size() > 0 ? rx_q[rx_q.size()-1].data : 8'hxx, rows[r].rx_last);
            @(negedge clk);
            #1;
            check($sformatf("r%0d_gnt_clear", r), gnt, 0);
            repeat (2) @(negedge clk);
        end

        do_reset();
        clear_logs();
        req_len = '0;
        req = 4'hF;
        wait_dones(5, 800);
        req = '0;
        for (int i = 0; i < 5; i++)
            if (i < done_q.size()) begin
                check($sformatf("rr_order%0d", i), idx_of(done_q[i].gnt), exp_order[i]);
                check($sformatf("rr_onehot%0d", i), $onehot(done_q[i].gnt), 1);
            end
        repeat (30) @(negedge clk);

        do_reset();
        clear_logs();
        req_len = 16'h0010;
        req = 4'b0010;
        k = 0;
        while (!gnt[1] && k < 20) begin
            @(negedge clk);
            #1;
            k++;
        end
        check("rot_gnt1", gnt, 4'b0010);
        req[3] = 1'b1;
        wait_dones(3, 800);
        req = '0;
        for (int i = 0; i < 3; i++)
            if (i < done_q.size())
                check($sformatf("rot_order%0d", i), idx_of(done_q[i].gnt), i == 1 ? 3 : 1);
        repeat (30) @(negedge clk);

        clear_logs();
        eng_mode = 0;
        req_len = '0;
        req = 4'b0001;
        wait_dones(1, 200);
        req = '0;
        if (done_q.size() > 0 && start_q.size() > 0) begin
            check("to_err", done_q[0].err, 1);
            check("to_latency", done_q[0].cyc - start_q[0].cyc, TO);
        end
        check("to_nrx", rx_q.size(), 0);
        check("to_nstart", start_q.size(), 1);
        eng_mode = 1;
        repeat (2) @(negedge clk);
        clear_logs();
        req = 4'b0100;
        wait_dones(1, 200);
        req = '0;
        if (done_q.size() > 0) begin
            check("to_next_err", done_q[0].err, 0);
            check("to_next_gnt", idx_of(done_q[0].gnt), 2);
        end
        check("to_next_rx", rx_q.size() > 0 ? rx_q[0].data : 8'hxx, 8'h88);
        repeat (3) @(negedge clk);

        clear_logs();
        req_len = 16'h0003;
        req = 4'b0001;
        k = 0;
        while (!(start_q.size() >= 2 && eng_busy) && k < 200) begin
            @(negedge clk);
            #1;
            k++;
        end
        check("mid_reached", start_q.size() >= 2 && eng_busy, 1);
        @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        check("mid_gnt", gnt, 0);
        check("mid_start_ack", {eng_start, tx_ack}, 0);
        check("mid_eng_tx", eng_tx, 0);
        check("mid_rx", {rx_valid, rx_data, rx_id}, 0);
        check("mid_done", {done, err}, 0);
        req = 4'hF;
        k = 0;
        while (eng_busy && k < 40) begin
            @(negedge clk);
            k++;
        end
        check("mid_no_done", done_q.size(), 0);
        clear_logs();
        reset_n = 1'b1;
        wait_dones(1, 200);
        req = '0;
        if (done_q.size() > 0)
            check("mid_first_gnt", idx_of(done_q[0].gnt), 0);
        repeat (100) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
